// File: rtl/reset_prompt_ctrl.sv
// "RESET?" prompt sequencer: debounces YES/NO, blinks the overlay per frame,
// and emits a one-cycle game reset on confirm or on answer timeout.
module reset_prompt_ctrl #(
    parameter int unsigned DEB_CYCLES     = 1000000,
    parameter int unsigned BLINK_FRAMES   = 30,
    parameter int unsigned TIMEOUT_FRAMES = 600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic game_over,
    input  logic frame_tick,
    input  logic btn_yes,
    input  logic btn_no,
    output logic prompt_en,
    output logic prompt_busy,
    output logic game_rst
);

    localparam int unsigned DEB_W   = (DEB_CYCLES > 1)     ? $clog2(DEB_CYCLES)     : 1;
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1)   ? $clog2(BLINK_FRAMES)   : 1;
    localparam int unsigned TMO_W   = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;

    typedef enum logic [1:0] {IDLE, PROMPT, FIRE, DISMISS} state_t;

    // Button conditioning; bit 0 = yes, bit 1 = no
    logic [1:0]            sync1, sync2, deb, deb_d;
    logic [1:0][DEB_W-1:0] deb_cnt;
    logic [1:0]            press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            deb     <= '0;
            deb_d   <= '0;
            deb_cnt <= '0;
        end else begin
            sync1 <= {btn_no, btn_yes};
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    assign press = deb & ~deb_d;

    state_t             state, state_nx;
    logic               phase, phase_nx;
    logic [BLINK_W-1:0] blink_cnt, blink_nx;
    logic [TMO_W-1:0]   tmo_cnt, tmo_nx;
    logic               go_q;
    logic               timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= 1'b0;
            blink_cnt   <= '0;
            tmo_cnt     <= '0;
            go_q        <= 1'b0;
            prompt_en   <= 1'b0;
            prompt_busy <= 1'b0;
            game_rst    <= 1'b0;
        end else begin
            state       <= state_nx;
            phase       <= phase_nx;
            blink_cnt   <= blink_nx;
            tmo_cnt     <= tmo_nx;
            go_q        <= game_over;
            prompt_en   <= (state_nx == PROMPT) & phase_nx;
            prompt_busy <= (state_nx == PROMPT);
            game_rst    <= (state_nx == FIRE);
        end
    end

    assign timeout_hit = frame_tick && (tmo_cnt == TMO_W'(TIMEOUT_FRAMES - 1));

    // Next state; game_over dropping wins over any press, yes wins over no
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        blink_nx = blink_cnt;
        tmo_nx   = tmo_cnt;
        case (state)
            IDLE: begin
                if (go_q) begin
                    state_nx = PROMPT;
                    phase_nx = 1'b1;
                    blink_nx = '0;
                    tmo_nx   = '0;
                end
            end
            PROMPT: begin
                if (!go_q) begin
                    state_nx = IDLE;
                end else begin
                    if (frame_tick) begin
                        if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                            blink_nx = '0;
                            phase_nx = ~phase;
                        end else begin
                            blink_nx = blink_cnt + BLINK_W'(1);
                        end
                        if (!timeout_hit) begin
                            tmo_nx = tmo_cnt + TMO_W'(1);
                        end
                    end
                    if (press[0] || timeout_hit) begin
                        state_nx = FIRE;
                    end else if (press[1]) begin
                        state_nx = DISMISS;
                    end
                end
            end
            FIRE: begin
                state_nx = IDLE;
            end
            DISMISS: begin
                if (!go_q) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reset_prompt_ctrl.sv
// Table-driven bench for reset_prompt_ctrl with small parameters; each vector
// holds inputs for a window of cycles, then checks outputs and reset pulses.
module tb_reset_prompt_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned BLK = 2;
    localparam int unsigned TMO = 6;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic game_over  = 1'b0;
    logic frame_tick = 1'b0;
    logic btn_yes    = 1'b0;
    logic btn_no     = 1'b0;
    logic prompt_en;
    logic prompt_busy;
    logic game_rst;

    reset_prompt_ctrl #(
        .DEB_CYCLES    (DEB),
        .BLINK_FRAMES  (BLK),
        .TIMEOUT_FRAMES(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .game_over  (game_over),
        .frame_tick (frame_tick),
        .btn_yes    (btn_yes),
        .btn_no     (btn_no),
        .prompt_en  (prompt_en),
        .prompt_busy(prompt_busy),
        .game_rst   (game_rst)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic  go;
        logic  yes;
        logic  no;
        int    tick_per;
        int    cycles;
        logic  en;
        logic  busy;
        int    rst;
    } vec_t;

    typedef struct {
        string name;
        logic  en;
        logic  busy;
        int    rst;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic go, input logic yes, input logic no,
                                input int tick_per, input int cycles,
                                input logic en, input logic busy, input int rst);
        vec_t v;
        v.name = nm; v.go = go; v.yes = yes; v.no = no;
        v.tick_per = tick_per; v.cycles = cycles;
        v.en = en; v.busy = busy; v.rst = rst;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the window's last posedge
    task automatic run_vec(input vec_t v);
        int   pulses;
        exp_t e;
        pulses = 0;
        e.name = v.name; e.en = v.en; e.busy = v.busy; e.rst = v.rst;
        sb.push_back(e);
        for (int k = 0; k < v.cycles; k++) begin
            game_over  = v.go;
            btn_yes    = v.yes;
            btn_no     = v.no;
            frame_tick = (v.tick_per > 0) && ((k % v.tick_per) == v.tick_per - 1);
            @(negedge clk);
            if (game_rst) pulses++;
        end
        frame_tick = 1'b0;
        e = sb.pop_front();
        check_int({e.name, ".prompt_en"},   int'(prompt_en),   int'(e.en));
        check_int({e.name, ".prompt_busy"}, int'(prompt_busy), int'(e.busy));
        check_int({e.name, ".rst_cycles"},  pulses,            e.rst);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        //               name            go yes no tick cyc en busy rst
        tbl.push_back(mk("idle_hold",     0, 0, 0,  0,  3, 0, 0, 0));
        tbl.push_back(mk("go_edge_n",     1, 0, 0,  0,  1, 0, 0, 0));
        tbl.push_back(mk("go_edge_n1",    1, 0, 0,  0,  1, 1, 1, 0));
        tbl.push_back(mk("blink_t1",      1, 0, 0, 10, 10, 1, 1, 0));
        tbl.push_back(mk("blink_t2",      1, 0, 0, 10, 10, 0, 1, 0));
        tbl.push_back(mk("blink_t3",      1, 0, 0, 10, 10, 0, 1, 0));
        tbl.push_back(mk("blink_t4",      1, 0, 0, 10, 10, 1, 1, 0));
        tbl.push_back(mk("blink_t5",      1, 0, 0, 10, 10, 1, 1, 0));
        tbl.push_back(mk("timeout_t6",    1, 0, 0, 10, 10, 0, 0, 1));
        tbl.push_back(mk("post_fire",     0, 0, 0,  0,  3, 0, 0, 0));
        tbl.push_back(mk("no_prompt",     1, 0, 0,  0,  2, 1, 1, 0));
        tbl.push_back(mk("no_pre_deb",    1, 0, 1,  0,  6, 1, 1, 0));
        tbl.push_back(mk("no_dismiss",    1, 0, 1,  0,  1, 0, 0, 0));
        tbl.push_back(mk("dismiss_hold",  1, 0, 1,  0, 10, 0, 0, 0));
        tbl.push_back(mk("dismiss_rel",   1, 0, 0,  0, 10, 0, 0, 0));
        tbl.push_back(mk("dismiss_exit",  0, 0, 0,  0,  3, 0, 0, 0));
        tbl.push_back(mk("reprompt",      1, 0, 0,  0,  2, 1, 1, 0));
        tbl.push_back(mk("yes_glitch1",   1, 1, 0,  0,  3, 1, 1, 0));
        tbl.push_back(mk("yes_gap1",      1, 0, 0,  0,  3, 1, 1, 0));
        tbl.push_back(mk("yes_glitch2",   1, 1, 0,  0,  3, 1, 1, 0));
        tbl.push_back(mk("yes_gap2",      1, 0, 0,  0,  3, 1, 1, 0));
        tbl.push_back(mk("yes_steady",    1, 1, 0,  0,  6, 1, 1, 0));
        tbl.push_back(mk("yes_fire",      1, 1, 0,  0,  1, 0, 0, 1));
        tbl.push_back(mk("yes_held",      1, 1, 0,  0, 10, 1, 1, 0));
        tbl.push_back(mk("yes_release",   1, 0, 0,  0, 10, 1, 1, 0));
        tbl.push_back(mk("both_pre_deb",  1, 1, 1,  0,  6, 1, 1, 0));
        tbl.push_back(mk("both_fire",     1, 1, 1,  0,  1, 0, 0, 1));
        tbl.push_back(mk("both_held",     1, 1, 1,  0, 10, 1, 1, 0));
        tbl.push_back(mk("both_release",  1, 0, 0,  0, 10, 1, 1, 0));
        tbl.push_back(mk("go_drop_n",     0, 0, 0,  0,  1, 1, 1, 0));
        tbl.push_back(mk("go_drop_n1",    0, 0, 0,  0,  1, 0, 0, 0));
        tbl.push_back(mk("go_drop_idle",  0, 0, 0,  0,  3, 0, 0, 0));
        tbl.push_back(mk("prio_prompt",   1, 0, 0,  0,  2, 1, 1, 0));
        tbl.push_back(mk("prio_yes_lead", 1, 1, 0,  0,  5, 1, 1, 0));
        tbl.push_back(mk("prio_drop",     0, 1, 0,  0,  2, 0, 0, 0));
        tbl.push_back(mk("prio_settle",   0, 0, 0,  0, 10, 0, 0, 0));
        tbl.push_back(mk("rst_prompt",    1, 0, 0,  0,  2, 1, 1, 0));

        repeat (2) @(negedge clk);
        check_int("reset.prompt_en",   int'(prompt_en),   0);
        check_int("reset.prompt_busy", int'(prompt_busy), 0);
        check_int("reset.game_rst",    int'(game_rst),    0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // Reset asserted mid-PROMPT: outputs drop without waiting for a clock
        #2 rst_n = 1'b0;
        #1;
        check_int("rst_mid_prompt.prompt_en",   int'(prompt_en),   0);
        check_int("rst_mid_prompt.prompt_busy", int'(prompt_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk("rst1_reprompt_n",  1, 0, 0, 0, 1, 0, 0, 0));
        run_vec(mk("rst1_reprompt_n1", 1, 0, 0, 0, 1, 1, 1, 0));

        // Reset asserted while FIRE is driving game_rst
        run_vec(mk("fire_pre_deb", 1, 1, 0, 0, 6, 1, 1, 0));
        run_vec(mk("fire_on",      1, 1, 0, 0, 1, 0, 0, 1));
        check_int("fire_on.game_rst_level", int'(game_rst), 1);
        #2 begin
            rst_n   = 1'b0;
            btn_yes = 1'b0;
        end
        #1;
        check_int("rst_mid_fire.game_rst",    int'(game_rst),    0);
        check_int("rst_mid_fire.prompt_busy", int'(prompt_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk("rst2_reprompt_n",  1, 0, 0, 0, 1, 0, 0, 0));
        run_vec(mk("rst2_reprompt_n1", 1, 0, 0, 0, 1, 1, 1, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
